// File: rtl/imem_loader.sv
`timescale 1ns/1ps
// imem_loader
// Boot-time writer for the instruction memory. Bytes arrive over a valid/ready
// stream. Each group of four is packed into one 32-bit instruction and written
// to byte address word_idx*4. While a load is running the CPU is held, so fetch
// never sees a partially loaded program.
//
// Ports
//   clk, rst            rising-edge clock; synchronous active-high reset
//   start, word_count   request a load of word_count words (1..DEPTH)
//   byte_valid/ready    incoming byte stream handshake, byte_data payload
//   mem_we/addr/wdata   instruction memory write port (mem_we is a 1-cycle strobe)
//   busy, cpu_hold      load in progress (both identical)
//   done, error         level status of the last load / last rejected start
module imem_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   word_count,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  mem_we,
    output logic [31:0]           mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  busy,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    // Places byte b into the lane selected by its position within the word.
    function automatic logic [31:0] insert_byte(input logic [31:0] word,
                                                input logic [1:0]  idx,
                                                input logic [7:0]  b);
        logic [1:0]  lane;
        logic [31:0] res;
        lane = BIG_ENDIAN ? (2'd3 - idx) : idx;
        res  = word;
        res[{lane, 3'b000} +: 8] = b;
        return res;
    endfunction

    state_t                state_r;
    state_t                state_s;
    logic [ADDR_WIDTH:0]   count_r;
    logic [ADDR_WIDTH-1:0] word_idx_r;
    logic [1:0]            byte_idx_r;
    logic [31:0]           word_r;
    logic                  byte_ready_r;
    logic                  mem_we_r;
    logic [31:0]           mem_addr_r;
    logic [31:0]           mem_wdata_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  error_r;
    logic                  byte_ready_s;
    logic                  mem_we_s;
    logic                  busy_s;

    logic                  start_ok_s;
    logic                  accept_s;
    logic                  last_word_s;
    logic [31:0]           word_ins_s;

    assign start_ok_s  = start && (word_count != {(ADDR_WIDTH+1){1'b0}}) && (word_count <= DEPTH);
    assign accept_s    = (state_r == ST_RECV) && byte_valid && byte_ready_r;
    assign last_word_s = ({1'b0, word_idx_r} == (count_r - {{ADDR_WIDTH{1'b0}}, 1'b1}));
    assign word_ins_s  = insert_byte(word_r, byte_idx_r, byte_data);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) state_s = ST_RECV;
                else            state_s = ST_IDLE;
            end
            ST_RECV: begin
                if (accept_s && (byte_idx_r == 2'd3)) state_s = ST_WRITE;
                else                                  state_s = ST_RECV;
            end
            ST_WRITE: begin
                if (last_word_s) state_s = ST_IDLE;
                else             state_s = ST_RECV;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Output decode from the next state, so the registered outputs line up with the state.
    always_comb begin
        byte_ready_s = 1'b0;
        mem_we_s     = 1'b0;
        busy_s       = 1'b0;
        case (state_s)
            ST_RECV: begin
                byte_ready_s = 1'b1;
                busy_s       = 1'b1;
            end
            ST_WRITE: begin
                mem_we_s     = 1'b1;
                busy_s       = 1'b1;
            end
            default: begin
                byte_ready_s = 1'b0;
                mem_we_s     = 1'b0;
                busy_s       = 1'b0;
            end
        endcase
    end

    // Output registers for the handshake, strobe and busy flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_ready_r <= 1'b0;
            mem_we_r     <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            byte_ready_r <= byte_ready_s;
            mem_we_r     <= mem_we_s;
            busy_r       <= busy_s;
        end
    end

    // Datapath: count latch, byte packing, write address/data and status levels.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r     <= {(ADDR_WIDTH+1){1'b0}};
            word_idx_r  <= {ADDR_WIDTH{1'b0}};
            byte_idx_r  <= 2'd0;
            word_r      <= 32'd0;
            mem_addr_r  <= 32'd0;
            mem_wdata_r <= 32'd0;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_ok_s) begin
                        count_r    <= word_count;
                        word_idx_r <= {ADDR_WIDTH{1'b0}};
                        byte_idx_r <= 2'd0;
                        word_r     <= 32'd0;
                        done_r     <= 1'b0;
                        error_r    <= 1'b0;
                    end else if (start) begin
                        done_r     <= 1'b0;
                        error_r    <= 1'b1;
                    end
                end
                ST_RECV: begin
                    if (accept_s) begin
                        word_r     <= word_ins_s;
                        byte_idx_r <= byte_idx_r + 2'd1;
                        // The fourth byte completes the word: stage the write port now.
                        if (byte_idx_r == 2'd3) begin
                            mem_addr_r  <= {{(30-ADDR_WIDTH){1'b0}}, word_idx_r, 2'b00};
                            mem_wdata_r <= word_ins_s;
                        end
                    end
                end
                ST_WRITE: begin
                    if (last_word_s) done_r <= 1'b1;
                    else             word_idx_r <= word_idx_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                end
                default: begin
                    done_r <= done_r;
                end
            endcase
        end
    end

    assign byte_ready = byte_ready_r;
    assign mem_we     = mem_we_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;
    assign busy       = busy_r;
    assign cpu_hold   = busy_r;
    assign done       = done_r;
    assign error      = error_r;

endmodule

// File: tb/tb_imem_loader.sv
`timescale 1ns/1ps
// Directed bench for imem_loader. Two instances share all inputs: one big-endian,
// one little-endian. A negedge monitor records every memory write of each.
module tb_imem_loader;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW:0]   word_count;
    logic          byte_valid;
    logic [7:0]    byte_data;

    logic          be_byte_ready, be_mem_we, be_busy, be_cpu_hold, be_done, be_error;
    logic [31:0]   be_mem_addr, be_mem_wdata;
    logic          le_byte_ready, le_mem_we, le_busy, le_cpu_hold, le_done, le_error;
    logic [31:0]   le_mem_addr, le_mem_wdata;

    imem_loader #(.ADDR_WIDTH(AW), .BIG_ENDIAN(1'b1)) dut_be (
        .clk(clk), .rst(rst), .start(start), .word_count(word_count),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(be_byte_ready),
        .mem_we(be_mem_we), .mem_addr(be_mem_addr), .mem_wdata(be_mem_wdata),
        .busy(be_busy), .cpu_hold(be_cpu_hold), .done(be_done), .error(be_error));

    imem_loader #(.ADDR_WIDTH(AW), .BIG_ENDIAN(1'b0)) dut_le (
        .clk(clk), .rst(rst), .start(start), .word_count(word_count),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(le_byte_ready),
        .mem_we(le_mem_we), .mem_addr(le_mem_addr), .mem_wdata(le_mem_wdata),
        .busy(le_busy), .cpu_hold(le_cpu_hold), .done(le_done), .error(le_error));

    always #5 clk = ~clk;

    int          cyc = 0;
    int          passed = 0;
    int          total = 0;
    int          overlap = 0;
    int          busy_cnt = 0;
    logic [31:0] be_addr_q[$];
    logic [31:0] be_data_q[$];
    int          be_cyc_q[$];
    logic [31:0] le_addr_q[$];
    logic [31:0] le_data_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (be_mem_we) begin
            be_addr_q.push_back(be_mem_addr);
            be_data_q.push_back(be_mem_wdata);
            be_cyc_q.push_back(cyc);
        end
        if (le_mem_we) begin
            le_addr_q.push_back(le_mem_addr);
            le_data_q.push_back(le_mem_wdata);
        end
        if ((be_mem_we && be_byte_ready) || (le_mem_we && le_byte_ready)) overlap++;
        if (be_busy || le_busy) busy_cnt++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        be_addr_q.delete();
        be_data_q.delete();
        be_cyc_q.delete();
        le_addr_q.delete();
        le_data_q.delete();
    endtask

    task automatic start_load(input logic [AW:0] cnt);
        start      = 1'b1;
        word_count = cnt;
        tick();
        start      = 1'b0;
    endtask

    // Presents one byte and waits (bounded) until the loader takes it.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit acc;
        int guard;
        if (gaps && ($urandom_range(0, 1) == 1)) begin
            byte_valid = 1'b0;
            byte_data  = 8'hA5;
            repeat ($urandom_range(1, 3)) tick();
        end
        byte_valid = 1'b1;
        byte_data  = b;
        acc        = 1'b0;
        guard      = 0;
        while (!acc && guard < 20) begin
            @(negedge clk);
            acc = be_byte_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        check("byte_accept", {31'd0, acc}, 32'd1);
    endtask

    task automatic send_two_words(input bit gaps);
        logic [7:0] bytes [8];
        bytes = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        for (int i = 0; i < 8; i++) send_byte(bytes[i], gaps);
        byte_valid = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b1;
        word_count = 11'd2;
        byte_valid = 1'b1;
        byte_data  = 8'hFF;

        // 1: reset held with start and byte_valid asserted.
        repeat (3) begin
            tick();
            check("rst_flags", {26'd0, be_byte_ready, be_mem_we, be_busy, be_cpu_hold, be_done, be_error}, 32'd0);
            check("rst_addr_data", be_mem_addr | be_mem_wdata, 32'd0);
        end
        start      = 1'b0;
        byte_valid = 1'b0;
        rst        = 1'b0;
        tick();
        check("rst_no_write", be_addr_q.size(), 32'd0);

        // 2: two words back-to-back.
        clear_q();
        start_load(11'd2);
        check("t2_busy_after_start", {30'd0, be_busy, be_cpu_hold}, 32'd3);
        send_two_words(1'b0);
        check("t2_we_last", {31'd0, be_mem_we}, 32'd1);
        tick();
        check("t2_done_idle", {29'd0, be_done, be_busy, be_cpu_hold}, 32'd4);
        check("t2_nwrites", be_addr_q.size(), 32'd2);
        check("t2_addr0", be_addr_q[0], 32'h0000_0000);
        check("t2_data0", be_data_q[0], 32'h1234_5678);
        check("t2_addr1", be_addr_q[1], 32'h0000_0004);
        check("t2_data1", be_data_q[1], 32'hDEAD_BEEF);
        check("t2_spacing", be_cyc_q[1] - be_cyc_q[0], 32'd5);
        check("t2_le_data0", le_data_q[0], 32'h7856_3412);

        // 3: same load with random gaps in byte_valid.
        clear_q();
        overlap = 0;
        start_load(11'd2);
        check("t3_done_cleared", {31'd0, be_done}, 32'd0);
        send_two_words(1'b1);
        repeat (2) tick();
        check("t3_done", {31'd0, be_done}, 32'd1);
        check("t3_nwrites", be_addr_q.size(), 32'd2);
        check("t3_data0", be_data_q[0], 32'h1234_5678);
        check("t3_addr1", be_addr_q[1], 32'h0000_0004);
        check("t3_data1", be_data_q[1], 32'hDEAD_BEEF);
        check("t3_ready_in_write", overlap, 32'd0);

        // 4: bad counts rejected, 1024 accepted.
        clear_q();
        busy_cnt = 0;
        start_load(11'd0);
        tick();
        check("t4_cnt0_status", {30'd0, be_error, be_done}, 32'd2);
        tick();
        start_load(11'd1025);
        tick();
        check("t4_cnt1025_error", {31'd0, be_error}, 32'd1);
        check("t4_busy_never", busy_cnt, 32'd0);
        check("t4_no_write", be_addr_q.size(), 32'd0);
        start_load(11'd1024);
        check("t4_cnt1024_status", {30'd0, be_error, be_busy}, 32'd1);

        // 5: reset mid-word aborts, next load uses fresh bytes only.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        clear_q();
        start_load(11'd2);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        byte_valid = 1'b0;
        rst = 1'b1;
        tick();
        check("t5_abort", {30'd0, be_busy, be_mem_we}, 32'd0);
        rst = 1'b0;
        tick();
        check("t5_no_write", be_addr_q.size(), 32'd0);
        start_load(11'd1);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        byte_valid = 1'b0;
        tick();
        check("t5_done", {31'd0, be_done}, 32'd1);
        check("t5_nwrites", be_addr_q.size(), 32'd1);
        check("t5_addr0", be_addr_q[0], 32'h0000_0000);
        check("t5_be_data", be_data_q[0], 32'h1122_3344);
        check("t5_le_data", le_data_q[0], 32'h4433_2211);

        // 6: little-endian packing, start pulsed mid-load is ignored.
        clear_q();
        start_load(11'd2);
        send_byte(8'h78, 1'b0);
        send_byte(8'h56, 1'b0);
        byte_valid = 1'b0;
        start_load(11'd1);
        check("t6_still_busy", {31'd0, le_busy}, 32'd1);
        send_byte(8'h34, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h04, 1'b0);
        byte_valid = 1'b0;
        tick();
        check("t6_done", {31'd0, le_done}, 32'd1);
        check("t6_nwrites", le_addr_q.size(), 32'd2);
        check("t6_le_data0", le_data_q[0], 32'h1234_5678);
        check("t6_be_data0", be_data_q[0], 32'h7856_3412);
        check("t6_le_addr1", le_addr_q[1], 32'h0000_0004);
        check("t6_le_data1", le_data_q[1], 32'h0403_0201);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
